// File: rtl/ram_arbiter_pkg.sv
// Shared types for the two-port RAM arbiter.
package ram_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int CNT_W = 8;

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-input round-robin selector; ptr names the preferred port.
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic grant,
   output logic valid
);

   assign valid = req0 | req1;
   assign grant = (req0 & req1) ? ptr : req1;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port byte RAM between instruction fetch (port 0)
// and CPU load/store (port 1) with a round-robin grant.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int size_addr = 8,
   parameter int timeout   = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req0,
   input  logic                 we0,
   input  logic [size_addr-1:0] addr0,
   input  logic [7:0]           wdata0,
   output logic                 done0,
   output logic                 err0,
   input  logic                 req1,
   input  logic                 we1,
   input  logic [size_addr-1:0] addr1,
   input  logic [7:0]           wdata1,
   output logic                 done1,
   output logic                 err1,
   output logic [7:0]           rdata,
   output logic                 busy,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic [size_addr-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   input  logic                 mem_ready_r,
   input  logic                 mem_ready_w,
   input  logic [7:0]           mem_rdata
);

   localparam logic [CNT_W-1:0] TO = CNT_W'(timeout);

   state_t               state;
   logic                 pointer;
   logic                 owner;
   logic                 we_lat;
   logic [CNT_W-1:0]     cnt;
   logic [CNT_W-1:0]     cnt_nxt;
   logic                 gnt;
   logic                 gnt_valid;
   logic                 ready;
   logic                 we_sel;
   logic [size_addr-1:0] addr_sel;
   logic [7:0]           wdata_sel;

   rr_arb2 u_rr (
      .req0  (req0),
      .req1  (req1),
      .ptr   (pointer),
      .grant (gnt),
      .valid (gnt_valid)
   );

   assign we_sel    = gnt ? we1 : we0;
   assign addr_sel  = gnt ? addr1 : addr0;
   assign wdata_sel = gnt ? wdata1 : wdata0;
   assign ready     = we_lat ? mem_ready_w : mem_ready_r;
   assign cnt_nxt   = cnt + CNT_W'(1);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         pointer   <= 1'b0;
         owner     <= 1'b0;
         we_lat    <= 1'b0;
         cnt       <= '0;
         done0     <= 1'b0;
         done1     <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
         rdata     <= 8'h00;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= 8'h00;
      end else begin
         unique case (state)
            IDLE: begin
               if (gnt_valid) begin
                  owner     <= gnt;
                  we_lat    <= we_sel;
                  mem_addr  <= addr_sel;
                  mem_wdata <= wdata_sel;
                  mem_read  <= ~we_sel;
                  mem_write <= we_sel;
                  state     <= ISSUE;
               end
            end
            ISSUE: begin
               mem_read  <= 1'b0;
               mem_write <= 1'b0;
               cnt       <= '0;
               state     <= WAIT;
            end
            WAIT: begin
               // Success and timeout both land in DONE; only err differs.
               if (ready || cnt_nxt == TO) begin
                  if (ready && !we_lat)
                     rdata <= mem_rdata;
                  done0   <= ~owner;
                  done1   <= owner;
                  err0    <= ~owner & ~ready;
                  err1    <= owner & ~ready;
                  pointer <= ~owner;
                  state   <= DONE;
               end else begin
                  cnt <= cnt_nxt;
               end
            end
            DONE: begin
               done0 <= 1'b0;
               done1 <= 1'b0;
               err0  <= 1'b0;
               err1  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
